// File: rtl/lcd_hd44780_responder.sv
// Character-LCD bus responder: decodes host reads/writes on EN falling edges,
// mirrors the 80-byte DDRAM, address counter, mode bits and busy timing.
module lcd_hd44780_responder #(
  parameter int BUSY_CYCLES       = 40,
  parameter int CLEAR_BUSY_CYCLES = 1600
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       lcd_EN,
  input  logic       lcd_RS,
  input  logic       lcd_RW,
  input  logic [7:0] lcd_DATA_in,
  output logic [7:0] lcd_DATA_out,
  output logic       lcd_DATA_oe,
  input  logic [6:0] disp_addr,
  output logic [7:0] disp_char,
  output logic       busy,
  output logic [6:0] addr_cnt,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       cmd_strobe,
  output logic [7:0] cmd_code,
  output logic       err_busy_write,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  localparam logic [31:0] L_BUSY_LOAD  = 32'(BUSY_CYCLES - 1);
  localparam logic [31:0] L_CLEAR_LOAD = 32'(CLEAR_BUSY_CYCLES - 1);

  // {mapped, index}: 0x00-0x27 -> 0..39, 0x40-0x67 -> 40..79
  function automatic logic [7:0] map_addr(input logic [6:0] a);
    if (a <= 7'h27) return {1'b1, a};
    if (a >= 7'h40 && a <= 7'h67) return {1'b1, a - 7'h18};
    return 8'h00;
  endfunction

  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == 7'h27) return 7'h40;
      if (a == 7'h67) return 7'h00;
      return a + 7'd1;
    end
    if (a == 7'h00) return 7'h67;
    if (a == 7'h40) return 7'h27;
    return a - 7'd1;
  endfunction

  state_t      r_state, w_state_nx;
  logic        r_en_q0, r_en_q1, r_rs_q0, r_rs_q1, r_rw_q0, r_rw_q1;
  logic [7:0]  r_data_q0, r_data_q1;
  logic [6:0]  r_addr, w_addr_nx;
  logic        r_inc, w_inc_nx, r_disp_on, w_disp_nx, r_cur_on, w_cur_nx, r_blink_on, w_blink_nx;
  logic        r_strobe, r_err, r_init_pend;
  logic [7:0]  r_code;
  logic [31:0] r_cnt, w_cnt_val;
  logic        w_cnt_load, w_clr_start;
  logic [6:0]  r_clr_idx;
  logic [7:0]  r_ddram [0:79];
  logic [7:0]  r_disp_char;
  logic        w_fall, w_accept, w_cmd_acc, w_dat_acc, w_rd_step, w_wr_busy;
  logic        w_is_clear, w_is_home;
  logic [7:0]  w_cur_map, w_disp_map, w_rd_byte;
  logic        w_mem_we;
  logic [6:0]  w_mem_idx;
  logic [7:0]  w_mem_wdata;

  // Transactions use the q1 copies: the bus values from the last cycle EN was high.
  assign w_fall     = r_en_q1 & ~r_en_q0;
  assign w_accept   = w_fall & ~r_rw_q1 & (r_state == S_IDLE) & ~r_init_pend;
  assign w_cmd_acc  = w_accept & ~r_rs_q1;
  assign w_dat_acc  = w_accept & r_rs_q1;
  assign w_rd_step  = w_fall & r_rw_q1 & r_rs_q1 & (r_state != S_CLEAR) & ~r_init_pend;
  assign w_wr_busy  = w_fall & ~r_rw_q1 & (r_state != S_IDLE);
  assign w_is_clear = (r_data_q1 == 8'h01);
  assign w_is_home  = (r_data_q1[7:1] == 7'b0000001);
  assign w_cur_map  = map_addr(r_addr);
  assign w_disp_map = map_addr(disp_addr);
  assign w_rd_byte  = w_cur_map[7] ? r_ddram[w_cur_map[6:0]] : 8'h00;

  // FSM: state register
  always_ff @(posedge clk_clk) begin
    if (reset_reset) r_state <= S_IDLE;
    else             r_state <= w_state_nx;
  end

  // FSM: next state and busy-counter load
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_val   = '0;
    w_clr_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_init_pend || (w_cmd_acc && w_is_clear)) begin
          w_state_nx  = S_CLEAR;
          w_cnt_load  = 1'b1;
          w_cnt_val   = L_CLEAR_LOAD;
          w_clr_start = 1'b1;
        end else if (w_accept) begin
          w_state_nx = S_BUSY;
          w_cnt_load = 1'b1;
          w_cnt_val  = (w_cmd_acc && w_is_home) ? L_CLEAR_LOAD : L_BUSY_LOAD;
        end
      end
      S_BUSY, S_CLEAR: if (r_cnt == '0) w_state_nx = S_IDLE;
      default:         w_state_nx = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy         = (r_state != S_IDLE);
    dbg_state    = r_state;
    lcd_DATA_oe  = r_en_q0 & r_rw_q0;
    lcd_DATA_out = 8'h00;
    if (lcd_DATA_oe) lcd_DATA_out = r_rs_q0 ? w_rd_byte : {busy, r_addr};
  end

  // Command decode by highest set bit; clear start takes priority.
  always_comb begin
    w_addr_nx  = r_addr;
    w_inc_nx   = r_inc;
    w_disp_nx  = r_disp_on;
    w_cur_nx   = r_cur_on;
    w_blink_nx = r_blink_on;
    if (w_clr_start) begin
      w_addr_nx = 7'h00;
      w_inc_nx  = 1'b1;
    end else if (w_dat_acc || w_rd_step) begin
      w_addr_nx = step_addr(r_addr, r_inc);
    end else if (w_cmd_acc) begin
      if (r_data_q1[7])             w_addr_nx = r_data_q1[6:0];
      else if (r_data_q1[6:5] != 0) w_addr_nx = r_addr;
      else if (r_data_q1[4]) begin
        if (!r_data_q1[3]) w_addr_nx = step_addr(r_addr, r_data_q1[2]);
      end else if (r_data_q1[3]) begin
        w_disp_nx  = r_data_q1[2];
        w_cur_nx   = r_data_q1[1];
        w_blink_nx = r_data_q1[0];
      end else if (r_data_q1[2]) w_inc_nx  = r_data_q1[1];
      else if (r_data_q1[1])     w_addr_nx = 7'h00;
    end
  end

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_idx   = '0;
    w_mem_wdata = '0;
    if (!reset_reset) begin
      if (r_state == S_CLEAR && r_clr_idx < 7'd80) begin
        w_mem_we    = 1'b1;
        w_mem_idx   = r_clr_idx;
        w_mem_wdata = 8'h20;
      end else if (w_dat_acc && w_cur_map[7]) begin
        w_mem_we    = 1'b1;
        w_mem_idx   = w_cur_map[6:0];
        w_mem_wdata = r_data_q1;
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_en_q0     <= 1'b0;
      r_en_q1     <= 1'b0;
      r_rs_q0     <= 1'b0;
      r_rs_q1     <= 1'b0;
      r_rw_q0     <= 1'b0;
      r_rw_q1     <= 1'b0;
      r_data_q0   <= 8'h00;
      r_data_q1   <= 8'h00;
      r_addr      <= 7'h00;
      r_inc       <= 1'b1;
      r_disp_on   <= 1'b0;
      r_cur_on    <= 1'b0;
      r_blink_on  <= 1'b0;
      r_strobe    <= 1'b0;
      r_code      <= 8'h00;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_clr_idx   <= 7'd0;
      r_init_pend <= 1'b1;
    end else begin
      r_en_q0     <= lcd_EN;
      r_en_q1     <= r_en_q0;
      r_rs_q0     <= lcd_RS;
      r_rs_q1     <= r_rs_q0;
      r_rw_q0     <= lcd_RW;
      r_rw_q1     <= r_rw_q0;
      r_data_q0   <= lcd_DATA_in;
      r_data_q1   <= r_data_q0;
      r_addr      <= w_addr_nx;
      r_inc       <= w_inc_nx;
      r_disp_on   <= w_disp_nx;
      r_cur_on    <= w_cur_nx;
      r_blink_on  <= w_blink_nx;
      r_strobe    <= w_cmd_acc;
      r_init_pend <= 1'b0;
      if (w_cmd_acc) r_code <= r_data_q1;
      if (w_wr_busy) r_err <= 1'b1;
      if (w_cnt_load)          r_cnt <= w_cnt_val;
      else if (r_cnt != '0)    r_cnt <= r_cnt - 32'd1;
      if (w_clr_start)         r_clr_idx <= 7'd0;
      else if (w_mem_we && r_state == S_CLEAR) r_clr_idx <= r_clr_idx + 7'd1;
    end
  end

  // Display port reads before the write lands, so a same-index collision sees the old byte.
  always_ff @(posedge clk_clk) begin
    if (w_mem_we) r_ddram[w_mem_idx] <= w_mem_wdata;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) r_disp_char <= 8'h00;
    else             r_disp_char <= w_disp_map[7] ? r_ddram[w_disp_map[6:0]] : 8'h00;
  end

  assign addr_cnt       = r_addr;
  assign entry_inc      = r_inc;
  assign display_on     = r_disp_on;
  assign cursor_on      = r_cur_on;
  assign blink_on       = r_blink_on;
  assign cmd_strobe     = r_strobe;
  assign cmd_code       = r_code;
  assign err_busy_write = r_err;
  assign disp_char      = r_disp_char;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Bench for lcd_hd44780_responder: directed scenarios plus random bus traffic
// compared against a linear-position model of the display.
module tb_lcd_hd44780_responder;

  logic       clk_clk = 1'b0;
  logic       reset_reset;
  logic       lcd_EN, lcd_RS, lcd_RW;
  logic [7:0] lcd_DATA_in, lcd_DATA_out;
  logic       lcd_DATA_oe;
  logic [6:0] disp_addr;
  logic [7:0] disp_char;
  logic       busy;
  logic [6:0] addr_cnt;
  logic       display_on, cursor_on, blink_on, entry_inc;
  logic       cmd_strobe;
  logic [7:0] cmd_code;
  logic       err_busy_write;
  logic [1:0] dbg_state;

  lcd_hd44780_responder #(.BUSY_CYCLES(40), .CLEAR_BUSY_CYCLES(1600)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .lcd_EN(lcd_EN), .lcd_RS(lcd_RS), .lcd_RW(lcd_RW),
    .lcd_DATA_in(lcd_DATA_in), .lcd_DATA_out(lcd_DATA_out), .lcd_DATA_oe(lcd_DATA_oe),
    .disp_addr(disp_addr), .disp_char(disp_char), .busy(busy), .addr_cnt(addr_cnt),
    .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on), .entry_inc(entry_inc),
    .cmd_strobe(cmd_strobe), .cmd_code(cmd_code), .err_busy_write(err_busy_write),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk_clk = ~clk_clk;

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: raw-address cell array, cursor, modes
  logic [7:0] m_mem [0:127];
  logic [6:0] m_addr;
  logic       m_inc, m_disp, m_cur, m_blink;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  function automatic bit is_mapped(input int a);
    return (a < 40) || (a >= 64 && a < 104);
  endfunction

  function automatic int lin(input int a);
    return (a < 40) ? a : a - 24;
  endfunction

  function automatic int unlin(input int p);
    return (p < 40) ? p : p + 24;
  endfunction

  // mapped cursors move around an 80-cell ring; others just count
  function automatic logic [6:0] next_addr(input logic [6:0] a, input logic inc);
    int ai = int'(a);
    if (is_mapped(ai)) return 7'(unlin((lin(ai) + (inc ? 1 : 79)) % 80));
    return 7'((ai + (inc ? 1 : 127)) % 128);
  endfunction

  task automatic m_clear();
    for (int p = 0; p < 80; p++) m_mem[unlin(p)] = 8'h20;
    m_addr = 7'h00;
    m_inc  = 1'b1;
  endtask

  task automatic m_reset();
    m_addr = 7'h00; m_inc = 1'b1; m_disp = 1'b0; m_cur = 1'b0; m_blink = 1'b0;
  endtask

  task automatic m_apply(input logic rs, input logic rw, input logic [7:0] d, output int exp_busy);
    exp_busy = 40;
    if (rw) begin
      exp_busy = 0;
      if (rs) m_addr = next_addr(m_addr, m_inc);
    end else if (rs) begin
      if (is_mapped(int'(m_addr))) m_mem[m_addr] = d;
      m_addr = next_addr(m_addr, m_inc);
    end else if (d >= 8'h80) m_addr = d[6:0];
    else if (d >= 8'h20) begin end
    else if (d >= 8'h10) begin
      if (d < 8'h18) m_addr = next_addr(m_addr, d[2]);
    end else if (d >= 8'h08) {m_disp, m_cur, m_blink} = d[2:0];
    else if (d >= 8'h04) m_inc = d[1];
    else if (d >= 8'h02) begin m_addr = 7'h00; exp_busy = 1600; end
    else if (d == 8'h01) begin m_clear(); exp_busy = 1600; end
  endtask

  // driver: EN high two cycles, sample the read bus while high, then drop EN
  task automatic bus_xfer(input logic rs, input logic rw, input logic [7:0] d,
                          output logic oe, output logic [7:0] q);
    lcd_RS = rs; lcd_RW = rw; lcd_DATA_in = d; lcd_EN = 1'b1;
    step(); step();
    oe = lcd_DATA_oe;
    q  = lcd_DATA_out;
    lcd_EN = 1'b0; lcd_RW = 1'b0;
    step(); step();
  endtask

  task automatic measure_busy(output int nb);
    nb = 0;
    while (busy === 1'b1 && nb < 4000) begin
      nb++;
      step();
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_addr"}, addr_cnt, m_addr);
    check({tag, "_inc"}, entry_inc, m_inc);
    check({tag, "_modes"}, {display_on, cursor_on, blink_on}, {m_disp, m_cur, m_blink});
  endtask

  task automatic do_op(input logic rs, input logic rw, input logic [7:0] d);
    logic       oe;
    logic [7:0] q, exp_rd;
    bit         rd_valid;
    int         exp_busy, nb;
    exp_rd   = rs ? m_mem[m_addr] : {1'b0, m_addr};
    rd_valid = !rs || is_mapped(int'(m_addr));
    bus_xfer(rs, rw, d, oe, q);
    check("xfer_oe", oe, rw);
    if (rw && rd_valid) check("rd_data", q, exp_rd);
    m_apply(rs, rw, d, exp_busy);
    check("strobe", cmd_strobe, !rs && !rw);
    if (!rs && !rw) check("cmd_code", cmd_code, d);
    check_state("op");
    measure_busy(nb);
    check("busy_len", nb, exp_busy);
    check("oe_idle", lcd_DATA_oe, 1'b0);
  endtask

  task automatic scan_disp(input string tag);
    logic [7:0] exp_q[$];
    for (int p = 0; p < 80; p++) exp_q.push_back(m_mem[unlin(p)]);
    for (int p = 0; p < 80; p++) begin
      disp_addr = 7'(unlin(p));
      step();
      check(tag, disp_char, exp_q.pop_front());
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_oe"}, lcd_DATA_oe, 1'b0);
    check({tag, "_out"}, lcd_DATA_out, 8'h00);
    check({tag, "_strobe"}, cmd_strobe, 1'b0);
    check({tag, "_code"}, cmd_code, 8'h00);
    check({tag, "_err"}, err_busy_write, 1'b0);
    check({tag, "_modes"}, {display_on, cursor_on, blink_on}, 3'b000);
    check({tag, "_addr"}, addr_cnt, 7'h00);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_inc"}, entry_inc, 1'b1);
  endtask

  initial begin
    int         nb, eb, k;
    logic       oe;
    logic [7:0] q;
    lcd_EN = 1'b0; lcd_RS = 1'b0; lcd_RW = 1'b0; lcd_DATA_in = 8'h00;
    disp_addr = 7'h00; reset_reset = 1'b1;
    m_reset();
    repeat (3) step();
    check_reset_outs("rst0");

    // power-up clear
    reset_reset = 1'b0;
    step();
    measure_busy(nb);
    check("init_busy", nb, 1600);
    m_clear();
    do_op(1'b0, 1'b1, 8'h00);
    scan_disp("init_disp");

    // display control then first character
    do_op(1'b0, 1'b0, 8'h0F);
    check("on_modes", {display_on, cursor_on, blink_on}, 3'b111);
    do_op(1'b1, 1'b0, 8'h41);
    check("c41_addr", addr_cnt, 7'h01);

    // end of line 1 wraps to line 2; decrement wraps 0x00 -> 0x67
    do_op(1'b0, 1'b0, 8'hA7);
    do_op(1'b1, 1'b0, 8'h5A);
    check("wrap_up_addr", addr_cnt, 7'h40);
    do_op(1'b0, 1'b0, 8'h04);
    do_op(1'b0, 1'b0, 8'h80);
    do_op(1'b1, 1'b0, 8'h11);
    check("wrap_dn_addr", addr_cnt, 7'h67);
    do_op(1'b0, 1'b0, 8'h06);

    // write while busy is dropped and flagged
    bus_xfer(1'b1, 1'b0, 8'h61, oe, q);
    m_apply(1'b1, 1'b0, 8'h61, eb);
    repeat (10) step();
    bus_xfer(1'b1, 1'b0, 8'h77, oe, q);
    check("busy_wr_err", err_busy_write, 1'b1);
    check("busy_wr_addr", addr_cnt, m_addr);
    bus_xfer(1'b0, 1'b1, 8'h00, oe, q);
    check("busy_status", q, {1'b1, m_addr});
    measure_busy(nb);
    check("busy_wr_short", nb < 40, 1'b1);

    // data read back
    do_op(1'b0, 1'b0, 8'hC5);
    do_op(1'b1, 1'b0, 8'h33);
    do_op(1'b0, 1'b0, 8'hC5);
    do_op(1'b1, 1'b1, 8'h00);
    check("rd_addr", addr_cnt, 7'h46);
    repeat (5) step();
    check("rd_no_busy", busy, 1'b0);

    // unmapped address: write discarded, counter still steps
    do_op(1'b0, 1'b0, 8'hB0);
    do_op(1'b1, 1'b0, 8'h99);
    check("unmap_addr", addr_cnt, 7'h31);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      k = int'($urandom_range(0, 19));
      if (k < 6)        do_op(1'b1, 1'b0, 8'($urandom_range(0, 255)));
      else if (k < 8)   do_op(1'b1, 1'b1, 8'h00);
      else if (k == 8)  do_op(1'b0, 1'b1, 8'h00);
      else if (k == 9)  do_op(1'b0, 1'b0, 8'h04 | 8'($urandom_range(0, 3)));
      else if (k == 10) do_op(1'b0, 1'b0, 8'h08 | 8'($urandom_range(0, 7)));
      else if (k < 13)  do_op(1'b0, 1'b0, 8'h10 | 8'($urandom_range(0, 15)));
      else if (k < 15)  do_op(1'b0, 1'b0, 8'h80 | 8'(unlin(int'($urandom_range(0, 79)))));
      else if (k == 15) do_op(1'b0, 1'b0, 8'h80 | 8'($urandom_range(0, 127)));
      else if (k < 18)  do_op(1'b0, 1'b0, 8'h20 + 8'($urandom_range(0, 95)));
      else if (k == 18) do_op(1'b0, 1'b0, 8'h00);
      else if ($urandom_range(0, 2) == 0) do_op(1'b0, 1'b0, 8'h02 | 8'($urandom_range(0, 1)));
      else do_op(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    end
    check("err_sticky", err_busy_write, 1'b1);
    scan_disp("rand_disp");

    // clear interrupted by reset, then restarted
    do_op(1'b0, 1'b0, 8'h0C);
    bus_xfer(1'b0, 1'b0, 8'h01, oe, q);
    check("clr_busy", busy, 1'b1);
    check("clr_addr", addr_cnt, 7'h00);
    repeat (29) step();
    reset_reset = 1'b1;
    step();
    check_reset_outs("rst_mid");
    reset_reset = 1'b0;
    m_reset();
    m_clear();
    step();
    measure_busy(nb);
    check("reclr_busy", nb, 1600);
    check_state("reclr");
    scan_disp("reclr_disp");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_responder.md
LCD_HD44780_RESPONDER -- requirements
Module: lcd_hd44780_responder

Synthesizable responder for the 8-bit character-LCD bus: it accepts host writes and reads, and mirrors display state for on-chip display and for checking.

Interface
REQ-001 The block SHALL have the parameter BUSY_CYCLES, default 40: busy duration in clocks after a normal command or data write.
REQ-002 The block SHALL have the parameter CLEAR_BUSY_CYCLES, default 1600: busy duration in clocks after clear or home. Legal values are >= 80.
REQ-003 The block SHALL have the port clk_clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have the port reset_reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have the ports lcd_EN, lcd_RS and lcd_RW, each input, 1 bit: host bus strobe, register select and read/write.
REQ-006 The block SHALL have the port lcd_DATA_in, input, 8 bits: host-driven data.
REQ-007 The block SHALL have the port lcd_DATA_out, output, 8 bits: responder read data.
REQ-008 The block SHALL have the port lcd_DATA_oe, output, 1 bit: responder drives the bus.
REQ-009 The block SHALL have the port disp_addr, input, 7 bits: display-side DDRAM read address.
REQ-010 The block SHALL have the port disp_char, output, 8 bits: DDRAM byte at disp_addr, registered with 1-cycle latency.
REQ-011 The block SHALL have the port busy, output, 1 bit: the busy flag.
REQ-012 The block SHALL have the port addr_cnt, output, 7 bits: the address counter.
REQ-013 The block SHALL have the ports display_on, cursor_on, blink_on and entry_inc, each output, 1 bit: the mode bits.
REQ-014 The block SHALL have the port cmd_strobe, output, 1 bit: 1-cycle pulse when any command is accepted.
REQ-015 The block SHALL have the port cmd_code, output, 8 bits: the last accepted command byte.
REQ-016 The block SHALL have the port err_busy_write, output, 1 bit: sticky flag for a write while busy, cleared only by reset.

Function
REQ-017 The block SHALL register lcd_EN/RS/RW/DATA_in once, then detect the EN falling edge as en_q1 & ~en_q0.
REQ-018 On the EN falling edge, the transaction SHALL use RS, RW and DATA as registered on the last cycle EN was high.
REQ-019 In a read, lcd_DATA_oe SHALL be 1 while the registered EN=1 and RW=1, and 0 otherwise.
REQ-020 For a read with RS=0, lcd_DATA_out SHALL be {busy, addr_cnt}.
REQ-021 For a read with RS=1, lcd_DATA_out SHALL be DDRAM[addr_cnt].
REQ-022 A data read SHALL step addr_cnt on the EN fall without setting busy.
REQ-023 The DDRAM SHALL have 80 bytes, mapping addr 0x00-0x27 to index 0-39 and 0x40-0x67 to index 40-79.
REQ-024 Data writes to unmapped addresses SHALL be discarded while addr_cnt still steps.
REQ-025 The address step SHALL be +1 if entry_inc=1, else -1, with wraps 0x27->0x40, 0x67->0x00, 0x00->0x67 and 0x40->0x27.
REQ-026 The state machine SHALL have three states: IDLE, BUSY and CLEAR.
REQ-027 A write on the EN fall SHALL be accepted only in IDLE.
REQ-028 A write in BUSY or CLEAR SHALL be ignored and SHALL set err_busy_write.
REQ-029 A data write (RS=0 for commands, RS=1 for data; RW=0) SHALL store DATA to DDRAM[addr_cnt], then step addr_cnt, then enter BUSY for BUSY_CYCLES.
REQ-030 For a command write, decode SHALL be by the highest set bit.
REQ-031 Command 0x01 (clear) SHALL enter CLEAR: write 0x20 to index 0..79 one per cycle, set addr_cnt=0, set entry_inc=1, and hold busy for CLEAR_BUSY_CYCLES total.
REQ-032 Commands 0x02-0x03 (home) SHALL set addr_cnt=0, keep DDRAM unchanged, and enter BUSY for CLEAR_BUSY_CYCLES.
REQ-033 Commands 0x04-0x07 SHALL set entry_inc=D1; D0 is ignored.
REQ-034 Commands 0x08-0x0F SHALL set display_on=D2, cursor_on=D1 and blink_on=D0.
REQ-035 Commands 0x10-0x1F SHALL step addr_cnt per D2 (1=+1) with wrap when D3=0; when D3=1 the display shift SHALL be ignored.
REQ-036 Commands 0x20-0x7F (function set / CGRAM address) SHALL be accepted with no state change.
REQ-037 Commands 0x80-0xFF SHALL set addr_cnt=D[6:0], with unmapped values held as given.
REQ-038 Every command except 0x01 and 0x02-0x03 SHALL enter BUSY for BUSY_CYCLES.
REQ-039 Every accepted command SHALL pulse cmd_strobe 1 cycle after the EN fall and update cmd_code.
REQ-040 busy SHALL be 1 from the cycle after the accepting EN fall and SHALL return to 0 exactly N cycles later, where N is the busy count.
REQ-041 If a display-side read and a host write hit the same index in one cycle, disp_char SHALL return the old byte.

Reset
REQ-042 While reset_reset=1, these outputs SHALL be 0: lcd_DATA_oe, lcd_DATA_out, cmd_strobe, cmd_code, err_busy_write, display_on, cursor_on, blink_on, addr_cnt and busy.
REQ-043 While reset_reset=1, entry_inc SHALL be 1.
REQ-044 After reset release, the block SHALL enter CLEAR: busy=1 for CLEAR_BUSY_CYCLES and DDRAM filled with 0x20.
REQ-045 Reset asserted mid-transaction or mid-CLEAR SHALL abort the transaction and restart this sequence.

Verification
REQ-046 The bench SHALL cover: reset release, wait 1600 cycles -> busy falls; status read returns 0x00; disp_char=0x20 for all 80 mapped addresses.
REQ-047 The bench SHALL cover: cmd 0x0F then data 0x41 -> display_on/cursor_on/blink_on=1; DDRAM[0x00]=0x41; addr_cnt=0x01; busy high 40 cycles after each write.
REQ-048 The bench SHALL cover: cmd 0xA7 then data 0x5A -> DDRAM[0x27]=0x5A; addr_cnt=0x40; cmd 0x04 then cmd 0x80 then one data write -> addr_cnt=0x67.
REQ-049 The bench SHALL cover: data write then a second write 10 cycles later -> second write ignored; err_busy_write=1 and stays 1 until reset.
REQ-050 The bench SHALL cover: cmd 0xC5, data 0x33, cmd 0xC5, data read -> lcd_DATA_oe=1 during EN high; lcd_DATA_out=0x33; addr_cnt=0x46; busy stays 0 after the read.
REQ-051 The bench SHALL cover: cmd 0x01, then reset asserted at cycle 30 of CLEAR -> outputs follow REQ-042/REQ-043 the next cycle; after release the full clear completes.
